// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: start bit (1), WIDTH data bits MSB first, stop bit (0).
// Completed words are offered on a valid/ready handshake; framing errors and overruns pulse for one cycle.
module serial_word_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic             framing_err,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] dout_n;
    logic             valid_n;
    logic             framing_err_n;
    logic             overrun_n;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_n       = state;
        cnt_n         = cnt;
        shreg_n       = shreg;
        dout_n        = dout;
        valid_n       = valid;
        framing_err_n = 1'b0;
        overrun_n     = 1'b0;

        // A consumer accept clears valid unless a delivery on this same edge reloads it.
        if (valid && ready) begin
            valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (din) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end
            DATA: begin
                shreg_n = {shreg[WIDTH-2:0], din};
                cnt_n   = cnt + CW'(1);
                if (cnt == LAST_BIT) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                // A bad stop bit returns to IDLE; it is never taken as the next start bit.
                state_n = IDLE;
                if (din) begin
                    framing_err_n = 1'b1;
                end else if (!valid || ready) begin
                    dout_n  = shreg;
                    valid_n = 1'b1;
                end else begin
                    overrun_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            dout        <= '0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            dout        <= dout_n;
            valid       <= valid_n;
            framing_err <= framing_err_n;
            overrun     <= overrun_n;
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed scenarios followed by randomized frames,
// compared against a frame-level model of the consumer-visible word and pulses.
module tb_serial_word_rx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         din;
    logic [W-1:0] dout;
    logic         valid;
    logic         ready;
    logic         framing_err;
    logic         overrun;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the word the consumer sees and whether it is still pending.
    logic [W-1:0] m_dout;
    logic         m_valid;

    serial_word_rx #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .dout        (dout),
        .valid       (valid),
        .ready       (ready),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge on which no frame completes; the consumer may take the pending word.
    task automatic tick_plain();
        if (m_valid && ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check({tag, "_dout"}, 32'(dout), 32'(m_dout));
        check({tag, "_ferr"}, 32'(framing_err), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    task automatic idle(input int n, input bit rnd_ready);
        din = 1'b0;
        for (int i = 0; i < n; i++) begin
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            tick_plain();
            check_quiet("idle");
        end
        ready = 1'b0;
    endtask

    // Sends a whole frame; ready is rdy_stop on the stop-bit edge and optionally random before it.
    task automatic send_frame(input string tag, input logic [W-1:0] word, input logic stop_bit,
                              input logic rdy_stop, input bit rnd_ready);
        logic exp_ferr;
        logic exp_ovr;
        din   = 1'b1;
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        tick_plain();
        for (int i = W - 1; i >= 0; i--) begin
            din   = word[i];
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            tick_plain();
            if (i == W / 2) check_quiet({tag, "_mid"});
        end
        din   = stop_bit;
        ready = rdy_stop;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (stop_bit) begin
            exp_ferr = 1'b1;
            if (m_valid && rdy_stop) m_valid = 1'b0;
        end else if (!m_valid || rdy_stop) begin
            m_dout  = word;
            m_valid = 1'b1;
        end else begin
            exp_ovr = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check({tag, "_dout"}, 32'(dout), 32'(m_dout));
        check({tag, "_ferr"}, 32'(framing_err), 32'(exp_ferr));
        check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
        din   = 1'b0;
        ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        logic         sb;
        logic         rs;

        m_dout  = '0;
        m_valid = 1'b0;

        // Reset held two cycles with the line high.
        reset = 1'b1;
        din   = 1'b1;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");

        // The first edge after release with din=1 is a start bit.
        reset = 1'b0;
        send_frame("a5c3", 16'hA5C3, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        ready = 1'b1;
        tick_plain();
        check("consume_valid", 32'(valid), 32'd0);
        check("consume_dout", 32'(dout), 32'hA5C3);
        ready = 1'b0;

        // Bad stop bit, then the line idles and a good frame follows.
        send_frame("ferr", 16'h1234, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b0);
        send_frame("00ff", 16'h00FF, 1'b0, 1'b0, 1'b0);
        ready = 1'b1;
        tick_plain();
        ready = 1'b0;

        // Overrun: the second word arrives with the first still pending.
        send_frame("beef", 16'hBEEF, 1'b0, 1'b0, 1'b0);
        send_frame("ovr", 16'h0001, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);

        // Accept on the stop edge frees the slot for the incoming word.
        send_frame("cafe", 16'hCAFE, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);

        // Reset mid-frame after 7 data bits; the word 0xCAFE is still pending.
        w   = 16'hFFFF;
        din = 1'b1;
        tick_plain();
        for (int i = 0; i < 7; i++) begin
            din = w[W - 1 - i];
            tick_plain();
        end
        reset = 1'b1;
        din   = 1'b0;
        @(posedge clk);
        #1;
        m_dout  = '0;
        m_valid = 1'b0;
        check_quiet("midreset");
        reset = 1'b0;
        send_frame("8001", 16'h8001, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Randomized frames with random gaps (including back-to-back) and random consumer activity.
        for (int n = 0; n < 40; n++) begin
            w  = W'($urandom);
            sb = ($urandom_range(0, 5) == 0);
            rs = 1'($urandom_range(0, 1));
            send_frame("rnd", w, sb, rs, 1'b1);
            idle(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
